// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Brief    : Shared types and constants for the MEM-stage memory access path.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_WAIT_CNT_W = 8;
    localparam int c_BYTE_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_access_byte_lane_extract.sv
`default_nettype none
// ============================================================================
//  Module   : byte_lane_extract
//  Brief    : Selects the full word or a zero-extended byte lane of read data.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_lane_extract
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [1:0]       addr,
    input  logic             lbu,
    output logic [WIDTH-1:0] read_data
);

    always_comb begin
        read_data = mem_rdata;
        if (lbu) begin
            read_data = {{(WIDTH-c_BYTE_W){1'b0}}, mem_rdata[int'(addr)*c_BYTE_W +: c_BYTE_W]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_access.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_access
//  Brief    : MEM-stage handshake engine: turns EX/MEM controls into a
//             req/ack data-memory transaction and stalls the pipeline meanwhile.
//             Optional macro MEM_MISALIGN_CHECK_EN rejects misaligned word
//             accesses and adds the sticky misalign_err output.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemToReg_in,
    input  logic             MemWrite_in,
    input  logic             LBU_in,
    input  logic [WIDTH-1:0] Result_in,
    input  logic [WIDTH-1:0] WriteData_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] ReadData_out,
    output logic             stall,
    output logic             timeout_err
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic             misalign_err
`endif
);

    localparam logic [c_WAIT_CNT_W-1:0] c_CNT_LIMIT = c_WAIT_CNT_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    we_q, we_d;
    logic [WIDTH-1:0]        addr_q, addr_d;
    logic [WIDTH-1:0]        wdata_q, wdata_d;
    logic [1:0]              lane_q, lane_d;
    logic                    lbu_q, lbu_d;
    logic [WIDTH-1:0]        rdata_q, rdata_d;
    logic [c_WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    w_access;
    logic [WIDTH-1:0]        w_lane_data;
`ifdef MEM_MISALIGN_CHECK_EN
    logic                    misalign_err_q, misalign_err_d;
    logic                    w_misaligned;

    assign w_misaligned = (MemWrite_in | ~LBU_in) & (Result_in[1:0] != 2'b00);
`endif

    assign w_access = MemToReg_in | MemWrite_in;

    // Lane select comes from the address latched at IDLE exit, not the live input.
    byte_lane_extract #(.WIDTH(WIDTH)) u_lane (
        .mem_rdata (mem_rdata),
        .addr      (lane_q),
        .lbu       (lbu_q),
        .read_data (w_lane_data)
    );

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        lane_d        = lane_q;
        lbu_d         = lbu_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`ifdef MEM_MISALIGN_CHECK_EN
        misalign_err_d = misalign_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_access) begin
                    we_d    = MemWrite_in;
                    addr_d  = {Result_in[WIDTH-1:2], 2'b00};
                    wdata_d = WriteData_in;
                    lane_d  = Result_in[1:0];
                    lbu_d   = LBU_in & ~MemWrite_in;
                    cnt_d   = '0;
`ifdef MEM_MISALIGN_CHECK_EN
                    if (w_misaligned) begin
                        state_d        = DONE;
                        misalign_err_d = 1'b1;
                        rdata_d        = '0;
                    end else
`endif
                    begin
                        state_d   = BUSY;
                        mem_req_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = w_lane_data;
                    end
                end else if (cnt_q == c_CNT_LIMIT) begin
                    state_d       = DONE;
                    mem_req_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    rdata_d       = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            lane_q        <= 2'b00;
            lbu_q         <= 1'b0;
            rdata_q       <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            lane_q        <= lane_d;
            lbu_q         <= lbu_d;
            rdata_q       <= rdata_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign ReadData_out = rdata_q;
    assign timeout_err  = timeout_err_q;
    // Gated by rst so every output reads 0 while reset is held.
    assign stall        = rst & w_access & (state_q != DONE);
`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_err = misalign_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_access
//  Brief    : Randomised transaction-level bench for mem_stage_access.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage_access;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             MemToReg_in, MemWrite_in, LBU_in;
    logic [WIDTH-1:0] Result_in, WriteData_in;
    logic             mem_req, mem_we;
    logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata, ReadData_out;
    logic             mem_ack, stall, timeout_err;
    logic             misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_rd;
    logic        exp_to;
    logic        exp_mis;
    logic        prev_done;

    always #5 clk = ~clk;

    mem_stage_access #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemToReg_in  (MemToReg_in),
        .MemWrite_in  (MemWrite_in),
        .LBU_in       (LBU_in),
        .Result_in    (Result_in),
        .WriteData_in (WriteData_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .ReadData_out (ReadData_out),
        .stall        (stall),
        .timeout_err  (timeout_err)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

`ifndef MEM_MISALIGN_CHECK_EN
    assign misalign_err = 1'b0;
`endif

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk_eq({tag, "_rdata"}, ReadData_out, exp_rd);
        chk_eq({tag, "_timeout"}, 32'(timeout_err), 32'(exp_to));
        chk_eq({tag, "_misalign"}, 32'(misalign_err), 32'(exp_mis));
    endtask

    // No access presented; spurious acks must not disturb anything.
    task automatic idle_cycles(input int n);
        MemToReg_in = 1'b0;
        MemWrite_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            mem_ack   = 1'($urandom % 2);
            mem_rdata = $urandom;
            @(negedge clk);
            chk_eq("idle_stall", 32'(stall), 32'd0);
            chk_eq("idle_req", 32'(mem_req), 32'd0);
            chk_eq("idle_rdata_hold", ReadData_out, exp_rd);
        end
        mem_ack   = 1'b0;
        prev_done = 1'b0;
    endtask

    // One transaction; ack_delay counts BUSY cycles before the ack cycle.
    task automatic do_access(input logic mw, input logic mtr, input logic lbu,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int ack_delay);
        logic mis;
        logic done;
        int   k;
        MemWrite_in  = mw;
        MemToReg_in  = mtr;
        LBU_in       = lbu;
        Result_in    = addr;
        WriteData_in = wd;
        mem_ack      = 1'b0;
        if (prev_done) begin
            #1;
            chk_eq("stall_in_done", 32'(stall), 32'd0);
            @(negedge clk);
        end
        #1;
        chk_eq("detect_stall", 32'(stall), 32'd1);
        chk_eq("detect_req", 32'(mem_req), 32'd0);
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = (mw || !lbu) && (addr[1:0] != 2'b00);
`endif
        if (mis) begin
            @(negedge clk);
            exp_rd  = 32'd0;
            exp_mis = 1'b1;
        end else begin
            done = 1'b0;
            k    = 0;
            while (!done && k <= TIMEOUT) begin
                @(negedge clk);
                chk_eq("busy_req", 32'(mem_req), 32'd1);
                chk_eq("busy_we", 32'(mem_we), 32'(mw));
                chk_eq("busy_addr", mem_addr, addr & 32'hFFFF_FFFC);
                if (mw) chk_eq("busy_wdata", mem_wdata, wd);
                chk_eq("busy_stall", 32'(stall), 32'd1);
                chk_eq("busy_rdata_hold", ReadData_out, exp_rd);
                if (k == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                    @(negedge clk);
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    if (!mw) exp_rd = lbu ? ((rd >> (8 * addr[1:0])) & 32'hFF) : rd;
                    done = 1'b1;
                end else if (k == TIMEOUT - 1) begin
                    @(negedge clk);
                    exp_rd = 32'd0;
                    exp_to = 1'b1;
                    done   = 1'b1;
                end
                k++;
            end
        end
        #1;
        chk_eq("done_req", 32'(mem_req), 32'd0);
        chk_eq("done_stall", 32'(stall), 32'd0);
        chk_status("done");
        prev_done = 1'b1;
    endtask

    task automatic reset_mid_busy();
        idle_cycles(1);
        MemWrite_in  = 1'b1;
        MemToReg_in  = 1'b0;
        Result_in    = 32'h0000_4008;
        WriteData_in = 32'hA5A5_5A5A;
        @(negedge clk);
        chk_eq("rst_pre_req", 32'(mem_req), 32'd1);
        chk_eq("rst_pre_we", 32'(mem_we), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_req", 32'(mem_req), 32'd0);
        chk_eq("rst_we", 32'(mem_we), 32'd0);
        chk_eq("rst_addr", mem_addr, 32'd0);
        chk_eq("rst_wdata", mem_wdata, 32'd0);
        chk_eq("rst_stall", 32'(stall), 32'd0);
        exp_rd  = 32'd0;
        exp_to  = 1'b0;
        exp_mis = 1'b0;
        chk_status("rst");
        rst         = 1'b1;
        MemWrite_in = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_req", 32'(mem_req), 32'd0);
        chk_eq("post_rst_stall", 32'(stall), 32'd0);
        prev_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic mw, mtr;
        rst          = 1'b0;
        MemToReg_in  = 1'b0;
        MemWrite_in  = 1'b0;
        LBU_in       = 1'b0;
        Result_in    = '0;
        WriteData_in = '0;
        mem_rdata    = '0;
        mem_ack      = 1'b0;
        exp_rd       = 32'd0;
        exp_to       = 1'b0;
        exp_mis      = 1'b0;
        prev_done    = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("reset_req", 32'(mem_req), 32'd0);
        chk_eq("reset_addr", mem_addr, 32'd0);
        chk_eq("reset_stall", 32'(stall), 32'd0);
        chk_status("reset");
        rst = 1'b1;
        idle_cycles(2);

        do_access(1'b0, 1'b1, 1'b0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 1);
        idle_cycles(1);
        do_access(1'b0, 1'b1, 1'b1, 32'h0000_1006, 32'd0, 32'h1122_3344, 0);
        do_access(1'b0, 1'b1, 1'b1, 32'h0000_1007, 32'd0, 32'h1122_3344, 2);
        idle_cycles(1);
        do_access(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, $urandom, 0);
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'd0, 32'hCAFE_F00D, 1);
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'd0, $urandom, TIMEOUT + 1);
        idle_cycles(2);
`ifdef MEM_MISALIGN_CHECK_EN
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_1002, 32'd0, $urandom, 0);
        idle_cycles(1);
`endif

        for (int t = 0; t < 40; t++) begin
            mw  = 1'($urandom % 2);
            mtr = mw ? 1'($urandom % 2) : 1'b1;
            do_access(mw, mtr, 1'($urandom % 2), $urandom, $urandom, $urandom,
                      (($urandom % 8) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1)));
            if (($urandom % 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        reset_mid_busy();
        do_access(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'd0, 32'h0BAD_F00D, 0);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs. It turns the registered memory controls into a handshaked transaction on a multi-cycle data-memory port.
- Decoded controls used: MemToReg, MemWrite, LBU, Result as address, WriteData.
- Returns load data toward MEM/WB.
- Drives a stall that holds the pipeline registers via their en inputs until the access completes.

Parameters:
- WIDTH, 32, data/address width
- TIMEOUT, 255, maximum wait cycles for mem_ack before the access is aborted (1..255)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- MemToReg_in  in  1  load request (from EX/MEM)
- MemWrite_in  in  1  store request (from EX/MEM)
- LBU_in  in  1  byte load, zero-extended; ignored when MemToReg_in=0
- Result_in  in  WIDTH  byte address
- WriteData_in  in  WIDTH  store data
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  WIDTH  word address: Result_in with [1:0] forced to 0
- mem_wdata  out  WIDTH  store data
- mem_rdata  in  WIDTH  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe
- ReadData_out  out  WIDTH  load result to MEM/WB
- stall  out  1  1 = hold PC/IF/ID/EX/MEM registers (en=0)
- timeout_err  out  1  sticky; set on timeout

Behaviour:
- access = MemToReg_in | MemWrite_in. If both are 1, the write takes priority.
- FSM states:
  - IDLE: if access, go to BUSY; mem_req is registered and rises next cycle. If no access, stall=0.
  - BUSY: mem_req=1, with addr/we/wdata registered at IDLE exit and held stable.
    - mem_ack=1 → capture data, go to DONE.
    - Wait counter reaches TIMEOUT → set timeout_err, ReadData_out=0, go to DONE.
  - DONE: mem_req=0, stall=0 for exactly one cycle so the pipeline advances; then go to IDLE.
- stall = access & (state != DONE). It is combinational, so the IDLE cycle that detects an access already stalls.
- Minimum access latency: 3 cycles (IDLE detect, BUSY with ack, DONE).
- Back-to-back accesses: after DONE, the IDLE cycle sees the new EX/MEM contents and restarts. No access is lost or duplicated.
- Load data handling:
  - Word load: ReadData_out = mem_rdata.
  - LBU: ReadData_out = zero-extended byte mem_rdata[8*Result_in[1:0] +: 8].
  - Lane select uses the registered address.
  - ReadData_out holds its value until the next load completes.
- Stores: ReadData_out is unchanged; mem_rdata is ignored.
- mem_ack outside BUSY is ignored.
- Wait counter: 8 bits, cleared on BUSY entry, saturates.
- Reset (rst=0, any state, including mid-BUSY): synchronously go to IDLE. All outputs return to 0: mem_req, mem_we, mem_addr, mem_wdata, ReadData_out, stall, timeout_err. The pending transaction is dropped without an ack wait.
- timeout_err clears only on reset.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- With the macro defined:
  - A word access (load with LBU=0, or store) with Result_in[1:0]!=0 skips BUSY: IDLE → DONE directly, no mem_req.
  - Output misalign_err (1 bit, sticky, reset 0) is set; ReadData_out=0.
- Without the macro: no misalign_err port; address bits [1:0] are silently dropped for word accesses.

Decomposition:
- Package mem_stage_pkg:
  - state enum {IDLE, BUSY, DONE}, 2-bit encoding
  - wait counter width constant (8)
  - byte-lane width constant (8)
- Sub-module byte_lane_extract (combinational): inputs mem_rdata, addr[1:0], LBU; output ReadData value. It is reused later by MEM/WB for lb/lh.

Test Plan:
- Reset mid-BUSY: assert rst=0 while mem_req=1 → next cycle state=IDLE, all outputs 0, no DONE cycle.
- Word load: Result=0x0000_1004, MemToReg=1, ack two cycles after mem_req with rdata=0xDEAD_BEEF → mem_addr=0x1004, ReadData_out=0xDEAD_BEEF, stall high 3 cycles, low in DONE.
- LBU: Result=0x0000_1006, rdata=0x1122_3344 → ReadData_out=0x0000_0022; Result=0x1007 → 0x0000_0011.
- Store then load back-to-back: sw WriteData=0xCAFE_F00D at 0x2000, then lw 0x2000 → mem_we=1 then 0, two separate req/ack pairs, no stall gap lost, ReadData_out=0xCAFE_F00D.
- Timeout: TIMEOUT=4, never ack → after 4 BUSY cycles timeout_err=1, ReadData_out=0, one DONE cycle, pipeline resumes.
- With MEM_MISALIGN_CHECK_EN: lw at 0x1002 → no mem_req, misalign_err=1, stall for 1 cycle then DONE.
